imm_rot_encoder: RTL and testbench
==================================

# imm_rot_encoder

Multi-cycle encoder that converts a 32-bit constant into an ARM data-processing immediate: an 8-bit value and a 4-bit rotate field. Decoding that pair means rotating the 8-bit value right by twice the rotate field, so `imm8` and `{rot4, 1'b0}` fed to the barrel shifter with shift type ROR (2'b11) reproduce the constant. The block sits beside the shifter in the instruction-generation and test path. It searches one rotation per clock behind a start/done handshake.

## Interface
Parameters: none; widths are fixed by the ARM encoding.

- `clk`  in  1  — sole clock, rising-edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — request; sampled only while `busy`=0.
- `value`  in  32  — constant to encode; captured on the accepting edge.
- `busy`  out  1  — search in progress.
- `done`  out  1  — one-cycle pulse when a result is published.
- `valid`  out  1  — published `value` is encodable.
- `imm8`  out  8  — encoded 8-bit immediate.
- `rot4`  out  4  — rotate field; the right-rotate amount is 2*`rot4`.

## Operation
- Reset values: all outputs 0; state IDLE; internal counter `r`=0; latched value 0.
- States:
  - IDLE: `busy`=0. On `start`=1 at a clock edge, latch `value`, set `r`=0, go to SEARCH.
  - SEARCH: `busy`=1. Each cycle compute `cand = latched ROL (2*r)`, using a 6-bit shift amount 0..30.
- Match condition: `cand[31:8]==0`.
- On match: at the next edge `imm8`=`cand[7:0]`, `rot4`=`r`, `valid`=1, `done`=1, go to IDLE.
- No match and `r`<15: `r` increments and the block stays in SEARCH.
- No match and `r`==15: at the next edge `imm8`=0, `rot4`=0, `valid`=0, `done`=1, go to IDLE.
- Tie-break: the smallest matching `r` wins.
  - `value`=0 gives `r`=0, `imm8`=0, `valid`=1.
  - Any `value`≤0xFF gives `r`=0.
- Results hold: `imm8`, `rot4` and `valid` keep their value until the next `done`.
- `start` in SEARCH: ignored and not queued; a changing `value` input has no effect.
- Reset mid-search: asynchronous return to reset values, no `done` pulse, search discarded.

## Timing
- Name the start-accepting edge E0. The evaluation for `r`=k completes at edge E(k+1).
- Latency from E0 to `done` is k+1 cycles for a match at `r`=k: minimum 1, maximum 16 (including the unencodable case).
- `done` is high for exactly one cycle. In that cycle `busy`=0 and state is IDLE.
  - `start`=1 during that cycle is accepted, so back-to-back requests lose no cycles.
  - The outputs then stay stable until the new `done`.
- `busy` rises at E0 and falls at the same edge `done` rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then `value`=0x000000FF with `start` at E0 -> at E1: `done`=1, `valid`=1, `imm8`=0xFF, `rot4`=0.
- `value`=0xFF000000 -> at E5: `done`=1, `valid`=1, `imm8`=0xFF, `rot4`=4. Check the round trip: `imm8` through the shifter with ROR and shift amount 8 gives 0xFF000000.
- Wrap-around cases:
  - `value`=0xF000000F -> `imm8`=0xFF, `rot4`=2 at E3.
  - `value`=0x000003FC -> `imm8`=0xFF, `rot4`=15 at E16.
- Unencodable `value`=0x00000101 -> at E16: `done`=1, `valid`=0, `imm8`=0, `rot4`=0. Toggle `start` and `value` mid-search; there must be no effect.
- Back-to-back: `value`=0 with `start` -> `done` at E1 with `imm8`=0, `valid`=1. Keep `start`=1 in the `done` cycle with `value`=0x00000104 -> second `done` 16 cycles later, `imm8`=0x41, `rot4`=15.
- Assert `rst` asynchronously at E3 during the 0x00000101 search -> outputs 0 immediately, no `done`. A new `start` after release completes normally.

Source files
------------

// File: rtl/imm_rot_if.sv
// Start/done handshake bundle for the ARM immediate encoder.
// start is sampled only while busy=0; done pulses one cycle with valid/imm8/rot4, which then hold.
interface imm_rot_if;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        valid;
  logic [7:0]  imm8;
  logic [3:0]  rot4;

  modport master (output start, value, input busy, done, valid, imm8, rot4);
  modport slave  (input start, value, output busy, done, valid, imm8, rot4);
endinterface

// File: rtl/imm_rot_encoder.sv
// Encodes a 32-bit constant as an ARM immediate (imm8 rotated right by 2*rot4),
// trying one rotation per clock and reporting the smallest rotate that fits.
module imm_rot_encoder (
  input  logic        clk,
  input  logic        rst,
  imm_rot_if.slave    bus,
  output logic        o_dbg_search
);

  typedef enum logic {S_IDLE = 1'b0, S_SEARCH = 1'b1} state_t;

  state_t      r_state, w_state_nx;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic [31:0] r_val, w_val_nx;
  logic [7:0]  r_imm8, w_imm8_nx;
  logic [3:0]  r_rot4, w_rot4_nx;
  logic        r_valid, w_valid_nx;
  logic        r_done, w_done_nx;

  logic [5:0]  w_sh;
  logic [63:0] w_dbl;
  logic [31:0] w_cand;

  // Rotate-left by 2*r: shift the doubled word and keep the upper half.
  assign w_sh   = {1'b0, r_cnt, 1'b0};
  assign w_dbl  = {r_val, r_val} << w_sh;
  assign w_cand = w_dbl[63:32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_val   <= 32'd0;
      r_imm8  <= 8'd0;
      r_rot4  <= 4'd0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_val   <= w_val_nx;
      r_imm8  <= w_imm8_nx;
      r_rot4  <= w_rot4_nx;
      r_valid <= w_valid_nx;
      r_done  <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_val_nx   = r_val;
    w_imm8_nx  = r_imm8;
    w_rot4_nx  = r_rot4;
    w_valid_nx = r_valid;
    w_done_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_val_nx   = bus.value;
          w_cnt_nx   = 4'd0;
          w_state_nx = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (w_cand[31:8] == 24'd0) begin
          w_imm8_nx  = w_cand[7:0];
          w_rot4_nx  = r_cnt;
          w_valid_nx = 1'b1;
          w_done_nx  = 1'b1;
          w_state_nx = S_IDLE;
        end else if (r_cnt == 4'd15) begin
          w_imm8_nx  = 8'd0;
          w_rot4_nx  = 4'd0;
          w_valid_nx = 1'b0;
          w_done_nx  = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + 4'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign bus.busy     = (r_state == S_SEARCH);
  assign bus.done     = r_done;
  assign bus.valid    = r_valid;
  assign bus.imm8     = r_imm8;
  assign bus.rot4     = r_rot4;
  assign o_dbg_search = (r_state == S_SEARCH);

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Directed bench for imm_rot_encoder: driver pushes hand-computed results, a negedge monitor checks each done.
module tb_imm_rot_encoder;
  localparam int W = 50; // {latency[4:0], valid, imm8[7:0], rot4[3:0], value[31:0]}

  logic clk;
  logic rst;
  logic dbg_search;
  imm_rot_if bus ();

  imm_rot_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .o_dbg_search (dbg_search)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic prev_busy = 1'b0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [5:0] sh);
    logic [63:0] d;
    d = {v, v} >> sh;
    return d[31:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] v, input int lat, input logic vld,
                      input logic [7:0] imm, input logic [3:0] rot, input bit push);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("send_wait_timeout", 32'd1, 32'd0);
    bus.start = 1'b1;
    bus.value = v;
    if (push) exp_q.push_back({lat[4:0], vld, imm, rot, v});
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((bus.busy || exp_q.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (bus.busy && !prev_busy) start_cyc = cyc;
    prev_busy = bus.busy;
    if (bus.done) begin
      check("busy_low_on_done", {31'd0, bus.busy}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("latency", cyc - start_cyc, {27'd0, e[49:45]});
        check("valid", {31'd0, bus.valid}, {31'd0, e[44]});
        check("imm8", {24'd0, bus.imm8}, {24'd0, e[43:36]});
        check("rot4", {28'd0, bus.rot4}, {28'd0, e[35:32]});
        if (e[44]) check("round_trip", ror32({24'd0, bus.imm8}, {1'b0, bus.rot4, 1'b0}), e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b0;
    bus.value = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_imm8", {24'd0, bus.imm8}, 32'd0);
    check("rst_rot4", {28'd0, bus.rot4}, 32'd0);
    rst = 1'b0;

    send(32'h0000_00FF, 1,  1'b1, 8'hFF, 4'd0,  1'b1);
    send(32'hFF00_0000, 5,  1'b1, 8'hFF, 4'd4,  1'b1);
    send(32'hF000_000F, 3,  1'b1, 8'hFF, 4'd2,  1'b1);
    send(32'h0000_03FC, 16, 1'b1, 8'hFF, 4'd15, 1'b1);
    send(32'h8000_0001, 2,  1'b1, 8'h06, 4'd1,  1'b1);
    send(32'h0003_FC00, 12, 1'b1, 8'hFF, 4'd11, 1'b1);
    wait_idle();

    // Unencodable, with start/value wiggled while the search runs.
    send(32'h0000_0101, 16, 1'b0, 8'h00, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = i[0];
      bus.value = $urandom_range(0, 255);
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Back-to-back: second start lands in the done cycle of the first.
    send(32'h0000_0000, 1,  1'b1, 8'h00, 4'd0,  1'b1);
    send(32'h0000_0104, 16, 1'b1, 8'h41, 4'd15, 1'b1);
    wait_idle();

    // Asynchronous reset mid-search: no done, outputs cleared at once.
    send(32'h0000_0101, 16, 1'b0, 8'h00, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_valid", {31'd0, bus.valid}, 32'd0);
    check("arst_imm8", {24'd0, bus.imm8}, 32'd0);
    check("arst_rot4", {28'd0, bus.rot4}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(32'h0000_00FF, 1, 1'b1, 8'hFF, 4'd0, 1'b1);
    wait_idle();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
